uc_grupo_1: RTL and testbench
=============================

# uc_grupo_1

Multicycle control unit for the single-issue RV64 datapath `fd_grupo_1`. It consumes `opcode` and `alu_flags` from the datapath and drives every datapath control input: `d_mem_we`, `rf_we`, `alu_cmd`, `alu_src`, `pc_src` and `rf_src`. A 4-state FSM is phase-locked to the datapath's divide-by-4 PC clock, so each instruction occupies exactly 4 `clk` cycles. The unit also keeps a retired-instruction counter and a sticky illegal-opcode flag for the bench and debug.

## Interface
- `CNT_WIDTH`, 16: width of the retired-instruction counter.
- `clk` in 1: rising-edge clock, the same net as the datapath `clk`.
- `rst` in 1: synchronous, active-high reset. The top level drives datapath `rst_n = ~rst`.
- `opcode` in 7: instruction bits [6:0] from the datapath.
- `alu_flags` in 4: {0, overflow, msb, zero} from the datapath. Bit 0 is used only for counting taken branches.
- `d_mem_we` out 1: data-memory write enable.
- `rf_we` out 1: register-file write enable.
- `alu_cmd` out 4: ALU command, see Operation.
- `alu_src` out 1: 0 selects rf, 1 selects immediate.
- `pc_src` out 1: 0 selects PC+4, 1 selects PC+imm when zero.
- `rf_src` out 1: 0 selects ALU, 1 selects d_mem.
- `phase` out 2: current FSM state encoding, for debug.
- `instr_count` out CNT_WIDTH: number of retired instructions.
- `branch_taken_count` out CNT_WIDTH: number of retired taken BEQs.
- `illegal` out 1: sticky flag, set when an unsupported opcode is seen.

## Operation
- States and encodings: DECODE=2'd1, EXEC=2'd2, COMMIT=2'd3, FETCH=2'd0.
- Fixed cycle: DECODE→EXEC→COMMIT→FETCH→DECODE. There are no stalls and no other transitions.
- Reset state is DECODE. This matches the datapath PC divider preset (2'b11), so the PC register updates on the `clk` edge that leaves COMMIT.
- Instruction classes:
  - R = 0110011
  - IALU = 0010011
  - LD = 0000011
  - SD = 0100011
  - BEQ = 1100011
  - Any other opcode is ILL.
- `alu_cmd` encoding:
  - 4'b0000: funct-driven, subtract allowed. Used for R.
  - 4'b0001: funct3-driven, never subtracts. Used for IALU.
  - 4'b0010: add. Used for LD and SD.
  - 4'b0011: subtract. Used for BEQ.
  - ILL drives 4'b0000.
- `alu_src` = 1 for IALU, LD and SD; 0 otherwise. Valid in every state.
- `rf_src` = 1 for LD only. Valid in every state.
- `rf_we` = 1 in COMMIT only, for R, IALU and LD.
- `d_mem_we` = 1 in COMMIT only, for SD.
- `pc_src` = 1 in COMMIT and FETCH for BEQ. Holding it through FETCH covers the clk→PC-clock skew, because the opcode is still the old instruction until the PC register updates.
- Outputs are combinational functions of state and `opcode` only. There is no path from `alu_flags` to any output.
- ILL is treated as a NOP: no writes and `pc_src` = 0. `illegal` sets on the COMMIT→FETCH edge and stays set until `rst`.
- `instr_count` increments on every COMMIT→FETCH edge, including for ILL.
- `branch_taken_count` increments on the COMMIT→FETCH edge when the class is BEQ and `alu_flags[0]` = 1.
- Both counters wrap modulo 2^CNT_WIDTH without saturating.

## Timing
- Reset values while `rst` is high:
  - `phase` = 2'd1 (DECODE); counters = 0; `illegal` = 0.
  - Every write enable is 0, since state is not COMMIT.
  - `pc_src` = 0.
- Reset has priority over all other events. Asserting `rst` mid-instruction (any state) returns to DECODE on the next edge, and the discarded instruction is not counted.
- After reset is released:
  - Edge 1 → EXEC; edge 2 → COMMIT; edge 3 → FETCH.
  - On edge 3 the register file and data memory write and the PC advances.
  - This repeats every 4 edges.
- Latency: 4 cycles per instruction, giving CPI 4.
- A counter update and a wrap on the same edge produce 0. A simultaneous `illegal` set and counter increment both take effect.

## Structure
- Package `uc_pkg` holds:
  - the state enum and its encodings;
  - the opcode constants;
  - the class enum {R, IALU, LD, SD, BEQ, ILL};
  - the `alu_cmd` constants.
- Sub-module `uc_decoder`: combinational opcode → class. It is shared with the future pipelined control.
- Top level: the state register, the two counters, the `illegal` flag and the output decode.

## Test plan
- Reset, then hold `opcode` = 0110011 → `phase` sequence 1,2,3,0,1. `rf_we` = 1 only while `phase` = 3. `alu_cmd` = 0000. `instr_count` = 1 after edge 3 and 2 after edge 7.
- `opcode` = 0000011 (LD) → `alu_src` = 1, `rf_src` = 1 and `alu_cmd` = 0010 in all states. `rf_we` = 1 only in COMMIT. `d_mem_we` = 0 throughout.
- `opcode` = 0100011 (SD) → `d_mem_we` = 1 only in COMMIT, `rf_we` = 0, `alu_src` = 1.
- `opcode` = 1100011 with `alu_flags` = 4'b0001 → `pc_src` = 1 in COMMIT and FETCH, `alu_cmd` = 0011, `branch_taken_count` +1. Repeat with flags 4'b0000 → counter unchanged.
- `opcode` = 1111111 → no enables asserted and `illegal` = 1 from edge 3 onward. `rst` clears it to 0.
- CNT_WIDTH = 4, 16 instructions → `instr_count` wraps to 0. Asserting `rst` while in EXEC → next `phase` = 1 and the count is not incremented.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared types and constants for the multicycle RV64 control unit.
// Holds the FSM state encodings, opcode values, instruction classes and ALU commands.
package uc_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_IALU = 3'd1,
    CLS_LD   = 3'd2,
    CLS_SD   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_ILL  = 3'd5
  } cls_e;

  localparam logic [3:0] ALU_FUNCT  = 4'b0000;
  localparam logic [3:0] ALU_FUNCT3 = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0011;

  // The instruction cycle is a fixed ring with no stalls.
  function automatic state_e next_state(input state_e s);
    case (s)
      DECODE:  next_state = EXEC;
      EXEC:    next_state = COMMIT;
      COMMIT:  next_state = FETCH;
      default: next_state = DECODE;
    endcase
  endfunction

endpackage

// File: rtl/uc_decoder.sv
// Combinational opcode-to-class decoder, shared with the future pipelined control.
module uc_decoder
  import uc_pkg::*;
(
  input  logic [6:0] opcode_i,
  output cls_e       cls_o
);

  always_comb begin
    cls_o = CLS_ILL;
    case (opcode_i)
      OP_R:    cls_o = CLS_R;
      OP_IALU: cls_o = CLS_IALU;
      OP_LD:   cls_o = CLS_LD;
      OP_SD:   cls_o = CLS_SD;
      OP_BEQ:  cls_o = CLS_BEQ;
      default: cls_o = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/uc_grupo_1.sv
// Multicycle control unit: 4-state FSM phase-locked to the datapath PC divider,
// plus retired-instruction / taken-branch counters and a sticky illegal flag.
module uc_grupo_1
  import uc_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [3:0]           alu_flags,
  output logic                 d_mem_we,
  output logic                 rf_we,
  output logic [3:0]           alu_cmd,
  output logic                 alu_src,
  output logic                 pc_src,
  output logic                 rf_src,
  output logic [1:0]           phase,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [CNT_WIDTH-1:0] branch_taken_count,
  output logic                 illegal
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
  logic                 illegal_q, illegal_d;
  cls_e                 cls;
  logic                 retire;

  uc_decoder u_decoder (
    .opcode_i (opcode),
    .cls_o    (cls)
  );

  // The instruction retires on the COMMIT->FETCH edge, together with the PC update.
  assign retire = (state_q == COMMIT);

  always_comb begin
    state_d     = next_state(state_q);
    instr_cnt_d = instr_cnt_q;
    br_cnt_d    = br_cnt_q;
    illegal_d   = illegal_q;
    if (retire) begin
      instr_cnt_d = instr_cnt_q + 1'b1;
      if (cls == CLS_BEQ && alu_flags[0]) begin
        br_cnt_d = br_cnt_q + 1'b1;
      end
      if (cls == CLS_ILL) begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DECODE;
      instr_cnt_q <= '0;
      br_cnt_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
      br_cnt_q    <= br_cnt_d;
      illegal_q   <= illegal_d;
    end
  end

  // Datapath controls depend only on state and opcode; alu_flags never reach them.
  always_comb begin
    alu_cmd  = ALU_FUNCT;
    alu_src  = 1'b0;
    rf_src   = 1'b0;
    rf_we    = 1'b0;
    d_mem_we = 1'b0;
    pc_src   = 1'b0;
    case (cls)
      CLS_R: begin
        alu_cmd = ALU_FUNCT;
        rf_we   = (state_q == COMMIT);
      end
      CLS_IALU: begin
        alu_cmd = ALU_FUNCT3;
        alu_src = 1'b1;
        rf_we   = (state_q == COMMIT);
      end
      CLS_LD: begin
        alu_cmd = ALU_ADD;
        alu_src = 1'b1;
        rf_src  = 1'b1;
        rf_we   = (state_q == COMMIT);
      end
      CLS_SD: begin
        alu_cmd  = ALU_ADD;
        alu_src  = 1'b1;
        d_mem_we = (state_q == COMMIT);
      end
      CLS_BEQ: begin
        alu_cmd = ALU_SUB;
        // Held through FETCH because the opcode stays valid until the PC clock edge.
        pc_src  = (state_q == COMMIT) || (state_q == FETCH);
      end
      default: begin
        alu_cmd = ALU_FUNCT;
      end
    endcase
  end

  assign phase              = state_q;
  assign instr_count        = instr_cnt_q;
  assign branch_taken_count = br_cnt_q;
  assign illegal            = illegal_q;

endmodule

// File: tb/tb_uc_grupo_1.sv
// Directed bench for uc_grupo_1: phase ring, per-class controls, counters, wrap and reset.
module tb_uc_grupo_1;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [3:0] alu_flags;

  logic        d_mem_we, rf_we, alu_src, pc_src, rf_src, illegal;
  logic [3:0]  alu_cmd;
  logic [1:0]  phase;
  logic [15:0] instr_count, branch_taken_count;

  logic        w_d_mem_we, w_rf_we, w_alu_src, w_pc_src, w_rf_src, w_illegal;
  logic [3:0]  w_alu_cmd;
  logic [1:0]  w_phase;
  logic [3:0]  w_instr_count, w_branch_taken_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uc_grupo_1 dut (
    .clk                (clk),
    .rst                (rst),
    .opcode             (opcode),
    .alu_flags          (alu_flags),
    .d_mem_we           (d_mem_we),
    .rf_we              (rf_we),
    .alu_cmd            (alu_cmd),
    .alu_src            (alu_src),
    .pc_src             (pc_src),
    .rf_src             (rf_src),
    .phase              (phase),
    .instr_count        (instr_count),
    .branch_taken_count (branch_taken_count),
    .illegal            (illegal)
  );

  uc_grupo_1 #(.CNT_WIDTH(4)) dut_w4 (
    .clk                (clk),
    .rst                (rst),
    .opcode             (opcode),
    .alu_flags          (alu_flags),
    .d_mem_we           (w_d_mem_we),
    .rf_we              (w_rf_we),
    .alu_cmd            (w_alu_cmd),
    .alu_src            (w_alu_src),
    .pc_src             (w_pc_src),
    .rf_src             (w_rf_src),
    .phase              (w_phase),
    .instr_count        (w_instr_count),
    .branch_taken_count (w_branch_taken_count),
    .illegal            (w_illegal)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from DECODE, checking every control in each of the 4 states.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [3:0] flags,
                           input logic [3:0] e_cmd, input logic e_asrc, input logic e_rsrc,
                           input logic e_rfwe, input logic e_memwe, input logic e_pc);
    logic [1:0] ph_seq [4];
    ph_seq[0] = 2'd1; ph_seq[1] = 2'd2; ph_seq[2] = 2'd3; ph_seq[3] = 2'd0;
    opcode    = op;
    alu_flags = flags;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk({name, "_phase"},    16'(phase),    16'(ph_seq[k]));
      chk({name, "_alu_cmd"},  16'(alu_cmd),  16'(e_cmd));
      chk({name, "_alu_src"},  16'(alu_src),  16'(e_asrc));
      chk({name, "_rf_src"},   16'(rf_src),   16'(e_rsrc));
      chk({name, "_rf_we"},    16'(rf_we),    16'((k == 2) ? e_rfwe : 1'b0));
      chk({name, "_d_mem_we"}, 16'(d_mem_we), 16'((k == 2) ? e_memwe : 1'b0));
      chk({name, "_pc_src"},   16'(pc_src),   16'((k >= 2) ? e_pc : 1'b0));
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 7'b0110011;
    alu_flags = 4'b0000;
    step();
    step();
    chk("rst_phase",    16'(phase), 16'd1);
    chk("rst_icount",   instr_count, 16'd0);
    chk("rst_bcount",   branch_taken_count, 16'd0);
    chk("rst_illegal",  16'(illegal), 16'd0);
    chk("rst_rf_we",    16'(rf_we), 16'd0);
    chk("rst_d_mem_we", 16'(d_mem_we), 16'd0);
    chk("rst_pc_src",   16'(pc_src), 16'd0);

    // R-type held: phase ring 1,2,3,0,1 and count after edges 3 and 7.
    rst = 1'b0;
    #1;
    chk("r_ph0", 16'(phase), 16'd1);
    chk("r_cmd", 16'(alu_cmd), 16'b0000);
    step(); chk("r_ph1", 16'(phase), 16'd2); chk("r_we1", 16'(rf_we), 16'd0);
    step(); chk("r_ph2", 16'(phase), 16'd3); chk("r_we2", 16'(rf_we), 16'd1);
    step(); chk("r_ph3", 16'(phase), 16'd0); chk("r_we3", 16'(rf_we), 16'd0);
    chk("r_cnt_e3", instr_count, 16'd1);
    step(); chk("r_ph4", 16'(phase), 16'd1);
    step(); step(); step();
    chk("r_cnt_e7", instr_count, 16'd2);
    step();

    run_instr("ld",  7'b0000011, 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ld_cnt", instr_count, 16'd3);
    run_instr("sd",  7'b0100011, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sd_cnt", instr_count, 16'd4);
    run_instr("ialu", 7'b0010011, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ialu_cnt", instr_count, 16'd5);
    run_instr("beqt", 7'b1100011, 4'b0001, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("beqt_bcnt", branch_taken_count, 16'd1);
    run_instr("beqn", 7'b1100011, 4'b0000, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("beqn_bcnt", branch_taken_count, 16'd1);
    chk("beqn_cnt", instr_count, 16'd7);
    chk("pre_ill", 16'(illegal), 16'd0);
    run_instr("ill", 7'b1111111, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ill_flag", 16'(illegal), 16'd1);
    chk("ill_cnt", instr_count, 16'd8);
    chk("ill_bcnt", branch_taken_count, 16'd1);
    step();
    chk("ill_sticky", 16'(illegal), 16'd1);

    // Reset mid-instruction (EXEC): back to DECODE, flag and counters cleared.
    rst = 1'b1;
    step();
    chk("rst2_phase",   16'(phase), 16'd1);
    chk("rst2_illegal", 16'(illegal), 16'd0);
    chk("rst2_icount",  instr_count, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_instr("wrap", 7'b0110011, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("wrap_w16", instr_count, 16'd16);
    chk("wrap_w4",  16'(w_instr_count), 16'd0);

    // Reset while in EXEC and while in COMMIT must not retire the instruction.
    step();
    chk("exec_phase", 16'(phase), 16'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("exec_rst_phase", 16'(phase), 16'd1);
    chk("exec_rst_cnt",   instr_count, 16'd0);
    step(); step();
    chk("commit_phase", 16'(phase), 16'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("commit_rst_phase", 16'(phase), 16'd1);
    chk("commit_rst_cnt",   instr_count, 16'd0);
    chk("commit_rst_w4",    16'(w_instr_count), 16'd0);
    run_instr("post", 7'b0110011, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_cnt", instr_count, 16'd1);
    chk("post_w4",  16'(w_instr_count), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
